itcm_fetch_responder: RTL

//  Responder end of the instruction-fetch req/resp channel driven by the fetch stage.

---
 rtl/itcm_fetch_responder_if.sv | 26 ++
 rtl/itcm_fetch_responder.sv | 104 ++++++++++
 2 files changed

// File: rtl/itcm_fetch_responder_if.sv
// Instruction-fetch req/resp channel between the fetch stage and the ITCM responder.
//   req_valid/req_ready/req_pc          : one fetch byte address per handshake
//   resp_valid/resp_ready/resp_err/instr: one in-order response per accepted request
// master = fetch stage, slave = responder.
interface itcm_fetch_responder_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [PC_WIDTH-1:0]    req_pc;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_err;
    logic [INSTR_WIDTH-1:0] resp_instr;

    modport master (
        output req_valid, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_err, resp_instr
    );

    modport slave (
        input  req_valid, req_pc, resp_ready,
        output req_ready, resp_valid, resp_err, resp_instr
    );
endinterface

// File: rtl/itcm_fetch_responder.sv
// Responder end of the instruction-fetch channel. Accepts one PC per handshake,
// reads a word from a synchronous single-port ITCM (1-cycle read latency) and
// returns instr/err in request order. A one-entry hold buffer keeps the word
// alive under response back-pressure; with resp_ready held high it runs at one
// fetch per cycle.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   fetch (slave) : req_valid/req_ready/req_pc, resp_valid/resp_ready/resp_err/resp_instr
//   itcm_cs_o     : ITCM read enable (never for error fetches)
//   itcm_addr_o   : ITCM word address, taken straight from req_pc
//   itcm_rdata_i  : ITCM read data, valid the cycle after itcm_cs_o
module itcm_fetch_responder #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ITCM_AW     = 14,
    parameter logic [PC_WIDTH-1:0]   ITCM_BASE   = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    itcm_fetch_responder_if.slave    fetch,
    output logic                     itcm_cs_o,
    output logic [ITCM_AW-1:0]       itcm_addr_o,
    input  logic [INSTR_WIDTH-1:0]   itcm_rdata_i
);
    // Range compare is done one bit wider so BASE + SIZE cannot wrap to 0.
    localparam logic [PC_WIDTH:0] BASE_X = {1'b0, ITCM_BASE};
    localparam logic [PC_WIDTH:0] SIZE_X = (PC_WIDTH+1)'(1) << (ITCM_AW + 2);
    localparam logic [PC_WIDTH:0] END_X  = BASE_X + SIZE_X;

    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_err_q, s1_err_d;
    logic                   hb_vld_q, hb_vld_d;
    logic                   hb_err_q, hb_err_d;
    logic [INSTR_WIDTH-1:0] hb_instr_q, hb_instr_d;

    logic                   err_req;
    logic                   accept;
    logic [PC_WIDTH:0]      pc_x;
    logic                   sel_vld;
    logic                   sel_err;
    logic [INSTR_WIDTH-1:0] sel_instr;

    assign pc_x    = {1'b0, fetch.req_pc};
    assign err_req = (fetch.req_pc[1:0] != 2'b00) | (pc_x < BASE_X) | (pc_x >= END_X);

    // Only one response can be outstanding: take a new request when the slot
    // is empty or the current response is leaving this cycle.
    assign fetch.req_ready = fetch.resp_ready | ~(s1_vld_q | hb_vld_q);
    assign accept          = fetch.req_valid & fetch.req_ready;
    assign itcm_cs_o       = accept & ~err_req;
    assign itcm_addr_o     = fetch.req_pc[ITCM_AW+1:2];

    // Hold buffer has priority; s1 and hb are never valid together.
    always_comb begin
        sel_vld   = 1'b0;
        sel_err   = 1'b0;
        sel_instr = '0;
        if (hb_vld_q) begin
            sel_vld   = 1'b1;
            sel_err   = hb_err_q;
            sel_instr = hb_instr_q;
        end else if (s1_vld_q) begin
            sel_vld   = 1'b1;
            sel_err   = s1_err_q;
            sel_instr = s1_err_q ? '0 : itcm_rdata_i;
        end
    end

    assign fetch.resp_valid = sel_vld;
    assign fetch.resp_err   = sel_err;
    assign fetch.resp_instr = sel_instr;

    always_comb begin
        s1_vld_d   = accept;
        s1_err_d   = accept ? err_req : s1_err_q;
        hb_vld_d   = hb_vld_q;
        hb_err_d   = hb_err_q;
        hb_instr_d = hb_instr_q;
        // ITCM data is only valid for one cycle, so a stalled read is parked here.
        if (s1_vld_q & ~fetch.resp_ready) begin
            hb_vld_d   = 1'b1;
            hb_err_d   = s1_err_q;
            hb_instr_d = sel_instr;
        end else if (hb_vld_q & fetch.resp_ready) begin
            hb_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            hb_vld_q   <= 1'b0;
            hb_err_q   <= 1'b0;
            hb_instr_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_err_q   <= s1_err_d;
            hb_vld_q   <= hb_vld_d;
            hb_err_q   <= hb_err_d;
            hb_instr_q <= hb_instr_d;
        end
    end
endmodule
